// File: rtl/mp_pkg.sv
// Shared multi-precision arithmetic package: operand widths and the
// controller state type used by both the adder and the subtractor.
package mp_pkg;

    localparam int MP_WIDTH      = 514;
    localparam int MP_LIMB_WIDTH = 257;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        FIN  = 2'd3
    } mp_state_t;

endpackage

// File: rtl/mp_limb_sub.sv
// Combinational single-limb subtractor with borrow in/out.
// d = a - b - bin; bout is the sign bit of the one-bit-wider difference.
module mp_limb_sub
    import mp_pkg::*;
#(
    parameter int LIMB_WIDTH = MP_LIMB_WIDTH
) (
    input  logic [LIMB_WIDTH-1:0] a,
    input  logic [LIMB_WIDTH-1:0] b,
    input  logic                  bin,
    output logic [LIMB_WIDTH-1:0] d,
    output logic                  bout
);

    logic [LIMB_WIDTH:0] diff;

    // Widened subtraction so the borrow falls out as the top bit
    always_comb begin
        diff = {1'b0, a} - {1'b0, b} - {{LIMB_WIDTH{1'b0}}, bin};
        d    = diff[LIMB_WIDTH-1:0];
        bout = diff[LIMB_WIDTH];
    end

endmodule

// File: rtl/mpsubber.sv
// Sequential multi-precision subtractor, C = A - B, one limb per cycle,
// least-significant limb first, with a registered borrow chain.
// Optional feature macro: MPSUB_ABS_EN -- when defined, a negative result
// is negated in a second pass (NEG state) so C = |A - B|, and borrow
// reports the sign of A - B.
// NUM_LIMBS is expected to be at least 2 (WIDTH a multiple of LIMB_WIDTH).
module mpsubber
    import mp_pkg::*;
#(
    parameter int WIDTH      = MP_WIDTH,
    parameter int LIMB_WIDTH = MP_LIMB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic             borrow,
    output logic             done
);

    localparam int NUM_LIMBS = WIDTH / LIMB_WIDTH;
    localparam int CNT_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
    localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);

    mp_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chain_q, chain_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             sign_q, sign_d;
    logic             done_q, done_d;

    logic [LIMB_WIDTH-1:0] sub_a, sub_b, sub_d;
    logic                  sub_bout;

    // One limb subtractor shared by the SUB and NEG passes
    mp_limb_sub #(
        .LIMB_WIDTH (LIMB_WIDTH)
    ) u_limb_sub (
        .a    (sub_a),
        .b    (sub_b),
        .bin  (chain_q),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // Operand select for the limb subtractor: A-B limbs, or 0-result in NEG
    always_comb begin
        sub_a = opa_q[LIMB_WIDTH-1:0];
        sub_b = opb_q[LIMB_WIDTH-1:0];
`ifdef MPSUB_ABS_EN
        if (state_q == NEG) begin
            sub_a = '0;
            sub_b = res_q[LIMB_WIDTH-1:0];
        end
`endif
    end

    // Next-state logic for the controller and datapath registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        sign_d  = sign_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                opa_d = A;
                opb_d = B;
                if (start) begin
                    cnt_d   = '0;
                    chain_d = 1'b0;
                    state_d = SUB;
                end
            end

            SUB: begin
                res_d   = {sub_d, res_q[WIDTH-1:LIMB_WIDTH]};
                opa_d   = opa_q >> LIMB_WIDTH;
                opb_d   = opb_q >> LIMB_WIDTH;
                chain_d = sub_bout;
                if (cnt_q == LAST_LIMB) begin
                    cnt_d  = '0;
                    sign_d = sub_bout;
`ifdef MPSUB_ABS_EN
                    if (sub_bout) begin
                        chain_d = 1'b0;
                        state_d = NEG;
                    end else begin
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
`else
                    state_d = FIN;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

`ifdef MPSUB_ABS_EN
            NEG: begin
                res_d   = {sub_d, res_q[WIDTH-1:LIMB_WIDTH]};
                chain_d = sub_bout;
                if (cnt_q == LAST_LIMB) begin
                    cnt_d   = '0;
                    state_d = FIN;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that also aborts an operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            chain_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            sign_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            sign_q  <= sign_d;
            done_q  <= done_d;
        end
    end

    assign C      = res_q;
    assign borrow = sign_q;
    assign done   = done_q;

endmodule

// File: doc/mpsubber.md
# mpsubber

Sequential multi-precision subtractor: computes C = A − B over 514-bit operands limb by limb, least-significant limb first, with a registered borrow chain. It is the counterpart of the multi-precision adder in the arithmetic datapath. The Montgomery/modular stages use it for conditional subtraction of the modulus. Operands and result use the same widths and the same start/done handshake as the adder, so the two blocks are interchangeable at the controller.

## Interface
- WIDTH, 514: operand and result width in bits.
- LIMB_WIDTH, 257: bits subtracted per cycle. WIDTH % LIMB_WIDTH must be 0. NUM_LIMBS = WIDTH/LIMB_WIDTH (default 2).
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request; sampled only in IDLE.
- A  input  WIDTH  minuend; sampled on the cycle start is accepted.
- B  input  WIDTH  subtrahend; sampled on the cycle start is accepted.
- C  output  WIDTH  difference A − B mod 2^WIDTH (or |A − B|, see Configuration).
- borrow  output  1  1 when A < B (unsigned).
- done  output  1  registered pulse; high exactly one cycle when C/borrow are valid.

## Operation
- States: IDLE, SUB, NEG (only when MPSUB_ABS_EN is defined), FIN.
- IDLE: A and B are loaded into operand shift registers every cycle. On start: limb counter ← 0, borrow register ← 0, next state SUB.
- SUB: one limb per cycle.
  - diff = opA[LIMB−1:0] − opB[LIMB−1:0] − borrow_reg, computed at LIMB_WIDTH+1 bits; borrow_out = diff sign bit.
  - Result register shifts right by LIMB_WIDTH with diff inserted at the MSBs; opA and opB shift right by LIMB_WIDTH; borrow_reg ← borrow_out.
  - When the counter reaches NUM_LIMBS−1: next state FIN, or NEG if ABS is enabled and borrow_out = 1.
- NEG: computes 0 − result over NUM_LIMBS cycles with a fresh borrow chain (borrow_reg cleared on entry), then FIN. The borrow output keeps the SUB-phase final borrow.
- FIN: done ← 1 for one cycle; next state IDLE.
- start is ignored outside IDLE; there is no queueing.
- After done, C and borrow hold until the next accepted start begins shifting.
- Wrap-around: A < B without ABS gives C = 2^WIDTH + A − B and borrow = 1.
- A = B gives C = 0 and borrow = 0.

## Timing
- Reset values: C = 0, borrow = 0, done = 0, state = IDLE, limb counter = 0.
- start accepted at cycle t → SUB occupies t+1 … t+NUM_LIMBS → done high at t+NUM_LIMBS+1. Default latency is 3 cycles, matching the adder.
- With ABS enabled and a negative result, latency is 2·NUM_LIMBS+1 cycles (default 5).
- A new start is accepted at the earliest in the cycle after done (IDLE).
- rst asserted mid-operation aborts on the next edge: state = IDLE, all outputs cleared, and no done is issued for the aborted request.
- start and rst high together: rst wins.

## Configuration
- MPSUB_ABS_EN
  - Defined: NEG state present; C = |A − B| and borrow indicates the sign.
  - Undefined: NEG state and its logic are absent; C is the two's-complement difference and borrow is the only sign indication.

## Structure
- Shared package mp_pkg:
  - MP_WIDTH = 514 and MP_LIMB_WIDTH = 257, also used by the adder.
  - State enum type mp_state_t (IDLE, SUB, NEG, FIN), 2 bits.
- One sub-module mp_limb_sub: purely combinational LIMB_WIDTH subtractor with ports a, b, bin, d, bout. It is reused by both the SUB and NEG phases through operand muxing.

## Test plan
- A = 5, B = 3, start for one cycle → done at t+3, C = 2, borrow = 0.
- A = 2^257, B = 1 (borrow crosses the limb boundary) → C = 2^257 − 1 (limb0 all ones, limb1 = 0), borrow = 0.
- A = 3, B = 5, MPSUB_ABS_EN undefined → C = 2^514 − 2, borrow = 1, latency 3.
- Same operands, MPSUB_ABS_EN defined → C = 2, borrow = 1, done at t+5.
- A = B = 2^514 − 1 → C = 0, borrow = 0. Back-to-back start in the cycle after done → second done at exactly +3 cycles.
- rst pulsed during SUB → no done pulse, C = 0, borrow = 0. A fresh start then completes normally.
